acq_search_ctrl: RTL
====================

Name: acq_search_ctrl

Overview:
- Sequencer for the acquisition threshold comparator.
- Walks a serial 2-D search grid (code phase × Doppler bin), one cell at a time.
- Per cell: waits for accumulator dumps, drives the comparator's aen strobe and clear, reads acq/acq8times, then either confirms the cell or slews the code NCO / steps the carrier NCO to the next cell.
- Sits between the correlator accumulators, the threshold comparator and the code/carrier NCO control.

Parameters:
NUM_BINS, 21, Doppler bins searched (index 0..NUM_BINS-1)
NUM_PHASES, 2046, half-chip code-phase cells per bin
MAX_DWELLS, 8, dumps allowed on one cell before it is abandoned
AEN_HI, 3, mclk cycles aen is held high per dump (minimum 2)
SETTLE, 4, dumps discarded after any slew/bin change

Ports:
mclk  in  1  system clock
res  in  1  asynchronous reset, active high
start  in  1  one-cycle pulse; starts a search from cell (0,0)
abort  in  1  level; forces return to IDLE
dump  in  1  one-cycle pulse; accumulator I/Q latched and valid
integmag  in  20  magnitude from comparator
acq  in  1  comparator single-hit flag
acq8times  in  1  comparator confirmed-lock flag
slew_done  in  1  one-cycle pulse; code NCO completed a half-chip slew
aen  out  1  comparator acquisition strobe
thr_clr  out  1  one-cycle pulse; clears comparator state (drive comparator res via inverter)
code_slew  out  1  one-cycle pulse; request half-chip slew
car_change  out  1  one-cycle pulse; carrier NCO loads dopp_bin
dopp_bin  out  5  current Doppler bin index
code_phase  out  11  current code-phase cell index
busy  out  1  high in any state other than IDLE/LOCKED/FAIL
locked  out  1  high in LOCKED
search_fail  out  1  high in FAIL
peak_mag  out  20  largest integmag seen in the current search
peak_bin  out  5  dopp_bin at peak_mag
peak_phase  out  11  code_phase at peak_mag

Behaviour:
- Reset (res=1, async): state IDLE; all outputs 0; internal counters 0.
- One clock domain (mclk). All outputs are registered.
- States: IDLE, CLEAR, SETTLE, WAITDUMP, STROBE, CHECK, SLEW, NEXTBIN, LOCKED, FAIL.
- IDLE: on start go to CLEAR.
  - Zero dopp_bin, code_phase and peak_*.
  - Pulse car_change once.
- CLEAR: pulse thr_clr for 1 cycle; zero dwell and settle counters; go to SETTLE.
- SETTLE: count dumps; after SETTLE dumps go to WAITDUMP.
- WAITDUMP: on dump go to STROBE; aen goes high the cycle after dump.
- STROBE: hold aen high for exactly AEN_HI cycles, then drive aen low. The comparator samples on the falling edge. Go to CHECK one cycle after aen falls.
- CHECK (1 cycle): evaluate the comparator result and update the peak, in this priority order.
  - Peak update: if integmag > peak_mag (strict), load peak_mag/peak_bin/peak_phase. Ties keep the older value.
  - acq8times=1: go to LOCKED.
  - acq=1 and dwell count < MAX_DWELLS-1: increment dwell count; go to WAITDUMP.
  - Otherwise: go to SLEW.
- SLEW: pulse code_slew once; wait for slew_done.
  - code_phase < NUM_PHASES-1: increment code_phase; go to CLEAR.
  - code_phase = NUM_PHASES-1: go to NEXTBIN.
- NEXTBIN: set code_phase to 0.
  - dopp_bin < NUM_BINS-1: increment dopp_bin; pulse car_change; go to CLEAR.
  - dopp_bin = NUM_BINS-1: go to FAIL.
- LOCKED / FAIL: hold all indices and peak_* values.
  - start: restarts as from IDLE.
  - abort: go to IDLE.
- abort=1 in any state: next cycle state IDLE; aen low; peak_* kept.
- abort and start in the same cycle: abort wins.
- start while busy: ignored.
- slew_done outside SLEW: ignored. dump outside SETTLE/WAITDUMP: ignored.
- dump arriving during STROBE/CHECK: dropped; no queuing.
- Reset mid-operation: all state cleared immediately; aen and all pulse outputs deassert asynchronously.

Test Plan:
- Reset and start: res pulse, then start, dumps every 20 cycles, acq=0 always → car_change pulse at start. Then SETTLE=4 dumps with aen low, then aen high for 3 cycles per dump. code_slew pulses after the first strobed dump; code_phase becomes 1 on slew_done.
- Confirm then lock: on cell (0,5) hold acq=1, assert acq8times on the 4th check → locked=1, dopp_bin=0, code_phase=5, no code_slew issued on that cell.
- Dwell exhaustion: acq=1, acq8times=0 indefinitely on one cell → exactly 8 strobes, then code_slew and thr_clr pulses.
- Bin wrap and fail: NUM_PHASES=4, NUM_BINS=2, acq=0 → after phase 3 of bin 0: code_phase=0, dopp_bin=1, car_change pulse. After phase 3 of bin 1: search_fail=1, busy=0.
- Peak tracking: integmag sequence 100, 300, 300, 200 across cells 0..3 → peak_mag=300, peak_phase=1.
- Abort/reset mid-STROBE: abort while aen high → aen=0 next cycle, state IDLE. Async res mid-STROBE → aen=0 immediately without an mclk edge.

Source files
------------

// File: rtl/acq_search_ctrl.sv
// acq_search_ctrl: serial code-phase x Doppler search sequencer that
// strobes the threshold comparator and steers the code/carrier NCOs.
module acq_search_ctrl #(
  parameter int NUM_BINS   = 21,
  parameter int NUM_PHASES = 2046,
  parameter int MAX_DWELLS = 8,
  parameter int AEN_HI     = 3,
  parameter int SETTLE     = 4
) (
  input  logic        mclk,
  input  logic        res,
  input  logic        start,
  input  logic        abort,
  input  logic        dump,
  input  logic [19:0] integmag,
  input  logic        acq,
  input  logic        acq8times,
  input  logic        slew_done,
  output logic        aen,
  output logic        thr_clr,
  output logic        code_slew,
  output logic        car_change,
  output logic [4:0]  dopp_bin,
  output logic [10:0] code_phase,
  output logic        busy,
  output logic        locked,
  output logic        search_fail,
  output logic [19:0] peak_mag,
  output logic [4:0]  peak_bin,
  output logic [10:0] peak_phase
);

  typedef enum logic [3:0] {
    S_IDLE,
    S_CLEAR,
    S_SETTLE,
    S_WAITDUMP,
    S_STROBE,
    S_CHECK,
    S_SLEW,
    S_NEXTBIN,
    S_LOCKED,
    S_FAIL
  } state_t;

  localparam int DW_W = $clog2(MAX_DWELLS + 2);
  localparam int ST_W = $clog2(SETTLE + 2);
  localparam int AH_W = $clog2(AEN_HI + 2);

  localparam logic [4:0]      LAST_BIN = 5'(NUM_BINS - 1);
  localparam logic [10:0]     LAST_PH  = 11'(NUM_PHASES - 1);
  localparam logic [DW_W-1:0] LAST_DW  = DW_W'(MAX_DWELLS - 1);
  localparam logic [ST_W-1:0] LAST_ST  = ST_W'(SETTLE - 1);
  localparam logic [AH_W-1:0] AH_LAST  = AH_W'(AEN_HI - 1);
  localparam logic [AH_W-1:0] AH_END   = AH_W'(AEN_HI);

  state_t r_state;
  state_t w_state_nxt;

  logic [DW_W-1:0] r_dwell;
  logic [DW_W-1:0] w_dwell_nxt;
  logic [ST_W-1:0] r_settle;
  logic [ST_W-1:0] w_settle_nxt;
  logic [AH_W-1:0] r_stb;
  logic [AH_W-1:0] w_stb_nxt;

  logic        r_aen;
  logic        w_aen_nxt;
  logic        r_clr;
  logic        w_clr_nxt;
  logic        r_slew;
  logic        w_slew_nxt;
  logic        r_car;
  logic        w_car_nxt;
  logic [4:0]  r_bin;
  logic [4:0]  w_bin_nxt;
  logic [10:0] r_ph;
  logic [10:0] w_ph_nxt;
  logic        r_busy;
  logic        r_locked;
  logic        r_fail;
  logic [19:0] r_pk_mag;
  logic [19:0] w_pk_mag_nxt;
  logic [4:0]  r_pk_bin;
  logic [4:0]  w_pk_bin_nxt;
  logic [10:0] r_pk_ph;
  logic [10:0] w_pk_ph_nxt;

  logic w_busy_nxt;
  logic w_locked_nxt;
  logic w_fail_nxt;

  always_ff @(posedge mclk or posedge res) begin
    if (res) begin
      r_state  <= S_IDLE;
      r_dwell  <= '0;
      r_settle <= '0;
      r_stb    <= '0;
      r_aen    <= 1'b0;
      r_clr    <= 1'b0;
      r_slew   <= 1'b0;
      r_car    <= 1'b0;
      r_bin    <= '0;
      r_ph     <= '0;
      r_busy   <= 1'b0;
      r_locked <= 1'b0;
      r_fail   <= 1'b0;
      r_pk_mag <= '0;
      r_pk_bin <= '0;
      r_pk_ph  <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_dwell  <= w_dwell_nxt;
      r_settle <= w_settle_nxt;
      r_stb    <= w_stb_nxt;
      r_aen    <= w_aen_nxt;
      r_clr    <= w_clr_nxt;
      r_slew   <= w_slew_nxt;
      r_car    <= w_car_nxt;
      r_bin    <= w_bin_nxt;
      r_ph     <= w_ph_nxt;
      r_busy   <= w_busy_nxt;
      r_locked <= w_locked_nxt;
      r_fail   <= w_fail_nxt;
      r_pk_mag <= w_pk_mag_nxt;
      r_pk_bin <= w_pk_bin_nxt;
      r_pk_ph  <= w_pk_ph_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_dwell_nxt  = r_dwell;
    w_settle_nxt = r_settle;
    w_stb_nxt    = r_stb;
    w_aen_nxt    = 1'b0;
    w_clr_nxt    = 1'b0;
    w_slew_nxt   = 1'b0;
    w_car_nxt    = 1'b0;
    w_bin_nxt    = r_bin;
    w_ph_nxt     = r_ph;
    w_pk_mag_nxt = r_pk_mag;
    w_pk_bin_nxt = r_pk_bin;
    w_pk_ph_nxt  = r_pk_ph;

    if (abort) begin
      w_state_nxt = S_IDLE;
    end else begin
      unique case (r_state)
        S_IDLE, S_LOCKED, S_FAIL: begin
          if (start) begin
            w_state_nxt  = S_CLEAR;
            w_bin_nxt    = '0;
            w_ph_nxt     = '0;
            w_pk_mag_nxt = '0;
            w_pk_bin_nxt = '0;
            w_pk_ph_nxt  = '0;
            w_car_nxt    = 1'b1;
          end
        end
        S_CLEAR: begin
          w_clr_nxt    = 1'b1;
          w_dwell_nxt  = '0;
          w_settle_nxt = '0;
          w_state_nxt  = (SETTLE == 0) ? S_WAITDUMP : S_SETTLE;
        end
        S_SETTLE: begin
          if (dump) begin
            if (r_settle == LAST_ST) begin
              w_state_nxt = S_WAITDUMP;
            end else begin
              w_settle_nxt = r_settle + 1'b1;
            end
          end
        end
        S_WAITDUMP: begin
          if (dump) begin
            w_state_nxt = S_STROBE;
            w_aen_nxt   = 1'b1;
            w_stb_nxt   = '0;
          end
        end
        S_STROBE: begin
          // aen drops after AEN_HI cycles; the comparator samples on
          // that falling edge, so CHECK waits one more cycle
          w_stb_nxt = r_stb + 1'b1;
          if (r_stb == AH_END) begin
            w_state_nxt = S_CHECK;
          end else if (r_stb != AH_LAST) begin
            w_aen_nxt = 1'b1;
          end
        end
        S_CHECK: begin
          if (integmag > r_pk_mag) begin
            w_pk_mag_nxt = integmag;
            w_pk_bin_nxt = r_bin;
            w_pk_ph_nxt  = r_ph;
          end
          if (acq8times) begin
            w_state_nxt = S_LOCKED;
          end else if (acq && (r_dwell < LAST_DW)) begin
            w_dwell_nxt = r_dwell + 1'b1;
            w_state_nxt = S_WAITDUMP;
          end else begin
            w_state_nxt = S_SLEW;
            w_slew_nxt  = 1'b1;
          end
        end
        S_SLEW: begin
          if (slew_done) begin
            if (r_ph < LAST_PH) begin
              w_ph_nxt    = r_ph + 1'b1;
              w_state_nxt = S_CLEAR;
            end else begin
              w_state_nxt = S_NEXTBIN;
            end
          end
        end
        S_NEXTBIN: begin
          w_ph_nxt = '0;
          if (r_bin < LAST_BIN) begin
            w_bin_nxt   = r_bin + 1'b1;
            w_car_nxt   = 1'b1;
            w_state_nxt = S_CLEAR;
          end else begin
            w_state_nxt = S_FAIL;
          end
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end

    w_locked_nxt = (w_state_nxt == S_LOCKED);
    w_fail_nxt   = (w_state_nxt == S_FAIL);
    w_busy_nxt   = (w_state_nxt != S_IDLE) && !w_locked_nxt && !w_fail_nxt;
  end

  assign aen         = r_aen;
  assign thr_clr     = r_clr;
  assign code_slew   = r_slew;
  assign car_change  = r_car;
  assign dopp_bin    = r_bin;
  assign code_phase  = r_ph;
  assign busy        = r_busy;
  assign locked      = r_locked;
  assign search_fail = r_fail;
  assign peak_mag    = r_pk_mag;
  assign peak_bin    = r_pk_bin;
  assign peak_phase  = r_pk_ph;

endmodule
